// File: rtl/sme_param.sv
// Parametrised string-match engine: serial string/pattern load, one start position evaluated per cycle.
module sme_param #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned IDX_W   = $clog2(STR_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index,
    output logic [IDX_W-1:0] match_cnt
);

    localparam int unsigned SA_W  = $clog2(STR_MAX);
    localparam int unsigned PA_W  = $clog2(PAT_MAX);
    localparam int unsigned PL_W  = $clog2(PAT_MAX + 1);
    localparam int unsigned CUR_W = $clog2(STR_MAX + PAT_MAX + 1);

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_STR = 3'd1,
        LOAD_PAT = 3'd2,
        SCAN     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state, next_state;

    logic [7:0]       str_mem [STR_MAX];
    logic [7:0]       pat_mem [PAT_MAX];
    logic [IDX_W-1:0] str_len;
    logic [PL_W-1:0]  pat_len;
    logic [IDX_W-1:0] pos;
    logic             acc_found;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] acc_cnt;

    logic             str_wr_c, str_first_c, pat_wr_c, pat_first_c;
    logic             scan_start_c, scan_last_c;
    logic [IDX_W-1:0] str_idx_c;
    logic [PL_W-1:0]  pat_idx_c;
    logic             pos_hit_c;
    logic             found_c;
    logic [IDX_W-1:0] idx_c;
    logic [IDX_W-1:0] cnt_c;
    logic [CUR_W-1:0] cur_c;
    logic [PL_W-1:0]  off_c;
    logic             elem_ok_c;

    // Out-of-range string reads return NUL so they never match a pattern char or a space
    function automatic logic [7:0] str_at(input logic [CUR_W-1:0] i);
        if (i < CUR_W'(STR_MAX)) return str_mem[i[SA_W-1:0]];
        else return 8'h00;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and load/scan control strobes
    always_comb begin
        next_state   = state;
        str_wr_c     = 1'b0;
        str_first_c  = 1'b0;
        pat_wr_c     = 1'b0;
        pat_first_c  = 1'b0;
        scan_start_c = 1'b0;
        scan_last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (isstring) begin
                    str_wr_c    = 1'b1;
                    str_first_c = 1'b1;
                    next_state  = LOAD_STR;
                end else if (ispattern) begin
                    pat_wr_c    = 1'b1;
                    pat_first_c = 1'b1;
                    next_state  = LOAD_PAT;
                end
            end
            LOAD_STR: begin
                if (isstring) str_wr_c = 1'b1;
                else          next_state = IDLE;
            end
            LOAD_PAT: begin
                if (ispattern) begin
                    pat_wr_c = 1'b1;
                end else begin
                    scan_start_c = 1'b1;
                    next_state   = SCAN;
                end
            end
            SCAN: begin
                if (pos == str_len) begin
                    scan_last_c = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Whole-pattern compare at start position pos; anchors are zero-width, other chars advance the cursor
    always_comb begin
        pos_hit_c = 1'b1;
        off_c     = '0;
        cur_c     = '0;
        elem_ok_c = 1'b1;
        for (int k = 0; k < int'(PAT_MAX); k++) begin
            cur_c     = CUR_W'(pos) + CUR_W'(off_c);
            elem_ok_c = 1'b1;
            if (PL_W'(k) < pat_len) begin
                if (pat_mem[PA_W'(k)] == CH_CARET) begin
                    elem_ok_c = (cur_c == '0) ||
                                ((cur_c <= CUR_W'(str_len)) && (str_at(cur_c - CUR_W'(1)) == CH_SPACE));
                end else if (pat_mem[PA_W'(k)] == CH_DOLLAR) begin
                    elem_ok_c = (cur_c == CUR_W'(str_len)) ||
                                ((cur_c < CUR_W'(str_len)) && (str_at(cur_c) == CH_SPACE));
                end else begin
                    elem_ok_c = (cur_c < CUR_W'(str_len)) &&
                                ((pat_mem[PA_W'(k)] == CH_DOT) || (str_at(cur_c) == pat_mem[PA_W'(k)]));
                    off_c     = off_c + PL_W'(1);
                end
            end
            pos_hit_c = pos_hit_c & elem_ok_c;
        end
    end

    // Load slot selection and accumulator update including the current position
    always_comb begin
        str_idx_c = str_first_c ? '0 : str_len;
        pat_idx_c = pat_first_c ? '0 : pat_len;
        found_c   = acc_found | pos_hit_c;
        idx_c     = acc_found ? acc_idx : (pos_hit_c ? pos : '0);
        cnt_c     = (pos_hit_c && (acc_cnt != '1)) ? acc_cnt + IDX_W'(1) : acc_cnt;
    end

    // Character storage; slots beyond capacity are dropped
    always_ff @(posedge clk) begin
        if (str_wr_c && (str_idx_c < IDX_W'(STR_MAX))) str_mem[str_idx_c[SA_W-1:0]] <= chardata;
        if (pat_wr_c && (pat_idx_c < PL_W'(PAT_MAX)))  pat_mem[pat_idx_c[PA_W-1:0]] <= chardata;
    end

    // Lengths, scan position, accumulators and registered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_len     <= '0;
            pat_len     <= '0;
            pos         <= '0;
            acc_found   <= 1'b0;
            acc_idx     <= '0;
            acc_cnt     <= '0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_cnt   <= '0;
        end else begin
            valid <= 1'b0;
            if (str_wr_c) begin
                str_len <= (str_idx_c < IDX_W'(STR_MAX)) ? str_idx_c + IDX_W'(1) : str_idx_c;
            end
            if (pat_wr_c) begin
                pat_len <= (pat_idx_c < PL_W'(PAT_MAX)) ? pat_idx_c + PL_W'(1) : pat_idx_c;
            end
            if (scan_start_c) begin
                pos       <= '0;
                acc_found <= 1'b0;
                acc_idx   <= '0;
                acc_cnt   <= '0;
            end else if (state == SCAN) begin
                pos       <= pos + IDX_W'(1);
                acc_found <= found_c;
                acc_idx   <= idx_c;
                acc_cnt   <= cnt_c;
            end
            if (scan_last_c) begin
                valid       <= 1'b1;
                match       <= found_c;
                match_index <= idx_c;
                match_cnt   <= cnt_c;
            end
        end
    end

endmodule

// File: tb/tb_sme_param.sv
// Directed self-checking bench for the parametrised string-match engine.
module tb_sme_param;

    localparam int unsigned STR_MAX = 32;
    localparam int unsigned PAT_MAX = 8;
    localparam int unsigned IDX_W   = 6;

    logic             clk;
    logic             reset;
    logic [7:0]       chardata;
    logic             isstring;
    logic             ispattern;
    logic             valid;
    logic             match;
    logic [IDX_W-1:0] match_index;
    logic [IDX_W-1:0] match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Result of the most recent pattern run
    logic             r_valid;
    logic             r_match;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    int               r_lat;
    logic             r_one_shot;

    sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .valid      (valid),
        .match      (match),
        .match_index(match_index),
        .match_cnt  (match_cnt)
    );

    // Clock: inputs change and outputs are sampled on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            chardata = s[i];
            isstring = 1'b1;
        end
        @(negedge clk);
        isstring = 1'b0;
        chardata = 8'h00;
    endtask

    // Sends a pattern, waits (bounded) for valid and captures the result
    task automatic run_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            @(negedge clk);
            chardata  = p[i];
            ispattern = 1'b1;
        end
        @(negedge clk);
        ispattern = 1'b0;
        chardata  = 8'h00;
        r_valid = 1'b0;
        r_lat   = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (valid) begin
                r_valid = 1'b1;
                r_lat   = c - 1;
                break;
            end
        end
        r_match = match;
        r_idx   = match_index;
        r_cnt   = match_cnt;
        @(negedge clk);
        r_one_shot = !valid;
    endtask

    task automatic test_reset();
        reset = 1'b0; chardata = 8'h00; isstring = 1'b0; ispattern = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, match, match_index, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b m=%b idx=%0d cnt=%0d, want all 0", valid, match, match_index, match_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_string("hello world");
        run_pattern("wor");
        n_checks++;
        if (r_valid !== 1'b1 || r_match !== 1'b1 || r_idx !== 6'd6 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL basic_wor: got v=%b m=%b idx=%0d cnt=%0d, want 1 1 6 1", r_valid, r_match, r_idx, r_cnt);
        end
        n_checks++;
        if (r_lat != 12) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 12", r_lat);
        end
        n_checks++;
        if (r_one_shot !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid_pulse: valid still high on second cycle, want one cycle");
        end
        n_checks++;
        if (r_match !== match || match !== 1'b1 || match_index !== 6'd6) begin
            n_fail++;
            $display("FAIL basic_hold: got m=%b idx=%0d after valid, want 1 6", match, match_index);
        end
    endtask

    task automatic test_back_to_back();
        run_pattern("^w");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd6 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL caret_w: got m=%b idx=%0d cnt=%0d, want 1 6 1", r_match, r_idx, r_cnt);
        end
        run_pattern("o$");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd4 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL o_dollar: got m=%b idx=%0d cnt=%0d, want 1 4 1", r_match, r_idx, r_cnt);
        end
        run_pattern("l.o");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd2 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL l_dot_o: got m=%b idx=%0d cnt=%0d, want 1 2 1", r_match, r_idx, r_cnt);
        end
        run_pattern("xyz");
        n_checks++;
        if (r_valid !== 1'b1 || r_match !== 1'b0 || r_idx !== 6'd0 || r_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL no_match_xyz: got v=%b m=%b idx=%0d cnt=%0d, want 1 0 0 0", r_valid, r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_anchors_only();
        send_string("a b c");
        run_pattern("^");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL caret_only: got m=%b idx=%0d cnt=%0d, want 1 0 3", r_match, r_idx, r_cnt);
        end
        run_pattern(".");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd5) begin
            n_fail++;
            $display("FAIL dot_only: got m=%b idx=%0d cnt=%0d, want 1 0 5", r_match, r_idx, r_cnt);
        end
        n_checks++;
        if (r_lat != 6) begin
            n_fail++;
            $display("FAIL short_latency: got %0d, want 6", r_lat);
        end
    endtask

    task automatic test_str_truncate();
        send_string("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn");
        run_pattern("efgh");
        n_checks++;
        if (r_match !== 1'b0 || r_idx !== 6'd0 || r_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL trunc_past_end: got m=%b idx=%0d cnt=%0d, want 0 0 0", r_match, r_idx, r_cnt);
        end
        n_checks++;
        if (r_lat != 33) begin
            n_fail++;
            $display("FAIL trunc_latency: got %0d, want 33", r_lat);
        end
        run_pattern("cdef");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd28 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL trunc_tail: got m=%b idx=%0d cnt=%0d, want 1 28 1", r_match, r_idx, r_cnt);
        end
        run_pattern("f$");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd31 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL trunc_dollar: got m=%b idx=%0d cnt=%0d, want 1 31 1", r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_pat_truncate();
        send_string("hello world");
        run_pattern("hello woZZ");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL pat_trunc_10: got m=%b idx=%0d cnt=%0d, want 1 0 1", r_match, r_idx, r_cnt);
        end
        run_pattern("hello wo");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL pat_trunc_8: got m=%b idx=%0d cnt=%0d, want 1 0 1", r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen_valid;
        send_string("abcabc");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chardata  = (i == 0) ? 8'h61 : (i == 1) ? 8'h62 : 8'h63;
            ispattern = 1'b1;
        end
        @(negedge clk);
        ispattern = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({valid, match, match_index, match_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_immediate: got v=%b m=%b idx=%0d cnt=%0d, want all 0", valid, match, match_index, match_cnt);
        end
        seen_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: got %0d valid pulses, want 0", seen_valid);
        end
        run_pattern("^$");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd1 || r_lat != 1) begin
            n_fail++;
            $display("FAIL empty_str: got m=%b idx=%0d cnt=%0d lat=%0d, want 1 0 1 1", r_match, r_idx, r_cnt, r_lat);
        end
        send_string("abcabc");
        run_pattern("abc");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd0 || r_cnt !== 6'd2 || r_lat != 7) begin
            n_fail++;
            $display("FAIL reload_abc: got m=%b idx=%0d cnt=%0d lat=%0d, want 1 0 2 7", r_match, r_idx, r_cnt, r_lat);
        end
        run_pattern("bca");
        n_checks++;
        if (r_match !== 1'b1 || r_idx !== 6'd1 || r_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL reload_bca: got m=%b idx=%0d cnt=%0d, want 1 1 1", r_match, r_idx, r_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_anchors_only();
        test_str_truncate();
        test_pat_truncate();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
